// File: rtl/dsss_pkg.sv
// Shared defaults, accumulator width helper and FSM state type for the DSSS despreader.
package dsss_pkg;

    localparam int unsigned SF_DEF     = 7;
    localparam int unsigned THRESH_DEF = 5;
    localparam int unsigned LOCK_N_DEF = 2;

    // Signed width able to hold -sf..+sf.
    function automatic int unsigned acc_w(input int unsigned sf);
        return $clog2(sf + 1) + 1;
    endfunction

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

endpackage

// File: rtl/dsss_lock_det.sv
// Lock hysteresis: lock toggles after LOCK_N consecutive graded bits that disagree with it.
module dsss_lock_det
    import dsss_pkg::*;
#(
    parameter  int unsigned LOCK_N = LOCK_N_DEF,
    localparam int unsigned RUN_W  = $clog2(LOCK_N + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic strobe_i,
    input  logic good_i,
    output logic lock_o
);

    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_N - 1);

    logic             lock_q, lock_d;
    logic [RUN_W-1:0] run_q, run_d;

    // A bit agreeing with the current lock state breaks any opposing run.
    always_comb begin
        lock_d = lock_q;
        run_d  = run_q;
        if (strobe_i) begin
            if (good_i == lock_q) begin
                run_d = '0;
            end else if (run_q == RUN_LAST) begin
                lock_d = ~lock_q;
                run_d  = '0;
            end else begin
                run_d = run_q + RUN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q <= 1'b0;
            run_q  <= '0;
        end else begin
            lock_q <= lock_d;
            run_q  <= run_d;
        end
    end

    assign lock_o = lock_q;

endmodule

// File: rtl/dsss_despreader.sv
// DSSS chip correlator: integrates +/-1 per chip over one PN period and dumps a hard bit.
module dsss_despreader
    import dsss_pkg::*;
#(
    parameter  int unsigned SF     = SF_DEF,
    parameter  int unsigned THRESH = THRESH_DEF,
    parameter  int unsigned LOCK_N = LOCK_N_DEF,
    localparam int unsigned ACC_W  = acc_w(SF)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    chip_valid,
    input  logic                    rx_chip,
    input  logic                    pn,
    input  logic                    sync,
    output logic                    bit_valid,
    output logic                    bit_out,
    output logic signed [ACC_W-1:0] corr,
    output logic                    lock
);

    localparam int unsigned CNT_W = $clog2(SF);
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(SF - 1);
    localparam logic signed [ACC_W-1:0] PLUS_ONE = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] MINUS_ONE = '1;

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic        [CNT_W-1:0] cnt_q, cnt_d;
    logic                    bit_valid_q, bit_valid_d;
    logic                    bit_out_q, bit_out_d;
    logic signed [ACC_W-1:0] corr_q, corr_d;

    logic signed [ACC_W-1:0] step;
    logic signed [ACC_W-1:0] sum;
    logic                    dump;
    logic                    good;

    assign step = (rx_chip == pn) ? PLUS_ONE : MINUS_ONE;
    assign sum  = acc_q + step;
    assign good = (int'(sum) >= int'(THRESH)) || (int'(sum) <= -int'(THRESH));

    // The accumulator is zeroed at each dump, so chip 0 of a back-to-back bit
    // simply adds onto zero; sync always restarts with the current chip as chip 0.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        bit_valid_d = 1'b0;
        bit_out_d   = bit_out_q;
        corr_d      = corr_q;
        dump        = 1'b0;
        if (chip_valid) begin
            if (sync) begin
                state_d = ACCUM;
                acc_d   = step;
                cnt_d   = CNT_W'(1);
            end else if (state_q == ACCUM) begin
                if (cnt_q == CNT_LAST) begin
                    dump        = 1'b1;
                    corr_d      = sum;
                    bit_out_d   = sum[ACC_W-1];
                    bit_valid_d = 1'b1;
                    acc_d       = '0;
                    cnt_d       = '0;
                end else begin
                    acc_d = sum;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            bit_valid_q <= 1'b0;
            bit_out_q   <= 1'b0;
            corr_q      <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            bit_valid_q <= bit_valid_d;
            bit_out_q   <= bit_out_d;
            corr_q      <= corr_d;
        end
    end

    dsss_lock_det #(
        .LOCK_N(LOCK_N)
    ) u_lock_det (
        .clk      (clk),
        .rst      (rst),
        .strobe_i (dump),
        .good_i   (good),
        .lock_o   (lock)
    );

    assign bit_valid = bit_valid_q;
    assign bit_out   = bit_out_q;
    assign corr      = corr_q;

endmodule

// File: tb/tb_dsss_despreader.sv
// Self-checking bench for dsss_despreader: vector table of bit periods plus hand-written corner sequences.
module tb_dsss_despreader;
    import dsss_pkg::*;

    localparam int unsigned ACC_W = acc_w(7);
    localparam logic [6:0]  PN    = 7'b1110010;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    chip_valid;
    logic                    rx_chip;
    logic                    pn;
    logic                    sync;
    logic                    bit_valid;
    logic                    bit_out;
    logic signed [ACC_W-1:0] corr;
    logic                    lock;

    dsss_despreader #(
        .SF     (7),
        .THRESH (5),
        .LOCK_N (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .chip_valid (chip_valid),
        .rx_chip    (rx_chip),
        .pn         (pn),
        .sync       (sync),
        .bit_valid  (bit_valid),
        .bit_out    (bit_out),
        .corr       (corr),
        .lock       (lock)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          corr;
        logic        bo;
        logic        lk;
        int unsigned due;
    } exp_t;

    typedef struct {
        logic [6:0] mask;
        logic       sync;
        int         corr;
        logic       bo;
        logic       lk;
    } vec_t;

    exp_t        sb[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;
    int unsigned pushes = 0;
    int unsigned strobes = 0;
    logic        mon_en = 1'b0;
    int          hold_corr = 0;
    logic        hold_bo = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            hold_corr = 0;
            hold_bo   = 1'b0;
        end
    end

    // Scoreboard side: every strobe must match the oldest pending expectation, on its cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bit_valid) begin
                exp_t e;
                strobes++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got strobe at cycle %0d expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    check("strobe_cycle", int'(cyc), int'(e.due));
                    check("corr", int'(corr), e.corr);
                    check("bit_out", int'(bit_out), int'(e.bo));
                    check("lock", int'(lock), int'(e.lk));
                end
                hold_corr = int'(corr);
                hold_bo   = bit_out;
            end else begin
                check("corr_hold", int'(corr), hold_corr);
                check("bit_out_hold", int'(bit_out), int'(hold_bo));
            end
        end
    end

    task automatic drive(input logic cv, input logic r, input logic p, input logic s);
        chip_valid = cv;
        rx_chip    = r;
        pn         = p;
        sync       = s;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_bit(input int c, input logic b, input logic l);
        exp_t e;
        e.corr = c;
        e.bo   = b;
        e.lk   = l;
        e.due  = cyc + 1;
        sb.push_back(e);
        pushes++;
    endtask

    // One PN period; stall_at >= 0 inserts 3 invalid cycles (with sync high) before that chip.
    task automatic send_bit(input logic [6:0] mask, input logic s0, input int stall_at,
                            input int c, input logic b, input logic l);
        for (int j = 0; j < 7; j++) begin
            logic p;
            if (j == stall_at) begin
                for (int k = 0; k < 3; k++) begin
                    drive(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1);
                end
            end
            p = PN[6-j];
            if (j == 6) expect_bit(c, b, l);
            drive(1'b1, p ^ mask[6-j], p, s0 && (j == 0));
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_bit_valid"}, int'(bit_valid), 0);
        check({tag, "_bit_out"}, int'(bit_out), 0);
        check({tag, "_corr"}, int'(corr), 0);
        check({tag, "_lock"}, int'(lock), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[13];
        tbl[0]  = '{7'b0000000, 1'b1,  7, 1'b0, 1'b0};
        tbl[1]  = '{7'b0000000, 1'b0,  7, 1'b0, 1'b1};
        tbl[2]  = '{7'b1111111, 1'b0, -7, 1'b1, 1'b1};
        tbl[3]  = '{7'b0001000, 1'b0,  5, 1'b0, 1'b1};
        tbl[4]  = '{7'b1010100, 1'b0,  1, 1'b0, 1'b1};
        tbl[5]  = '{7'b0000000, 1'b0,  7, 1'b0, 1'b1};
        tbl[6]  = '{7'b1101101, 1'b0, -3, 1'b1, 1'b1};
        tbl[7]  = '{7'b0100001, 1'b0,  3, 1'b0, 1'b0};
        tbl[8]  = '{7'b1111000, 1'b0, -1, 1'b1, 1'b0};
        tbl[9]  = '{7'b1111110, 1'b0, -5, 1'b1, 1'b0};
        tbl[10] = '{7'b0011000, 1'b0,  3, 1'b0, 1'b0};
        tbl[11] = '{7'b1111111, 1'b0, -7, 1'b1, 1'b0};
        tbl[12] = '{7'b1000000, 1'b0,  5, 1'b0, 1'b1};

        rst = 1'b1;
        chip_valid = 1'b1;
        rx_chip = 1'b0;
        pn = 1'b1;
        sync = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;
        mon_en = 1'b1;

        // Sync with chip_valid low must be ignored: no accumulation, no strobe.
        for (int k = 0; k < 8; k++) drive(1'b0, 1'b1, 1'b1, 1'b1);
        // Valid chips without any sync leave the FSM idle.
        for (int k = 0; k < 9; k++) drive(1'b1, 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < 13; i++) begin
            send_bit(tbl[i].mask, tbl[i].sync, -1, tbl[i].corr, tbl[i].bo, tbl[i].lk);
        end

        // Stall between chips 2 and 3.
        send_bit(7'b0000000, 1'b0, 3, 7, 1'b0, 1'b1);

        // Resync at chip 4 of a fully inverted partial period.
        for (int j = 0; j < 4; j++) drive(1'b1, ~PN[6-j], PN[6-j], 1'b0);
        send_bit(7'b1111111, 1'b1, -1, -7, 1'b1, 1'b1);

        // Reset arriving at chip 5 of a period.
        for (int j = 0; j < 5; j++) drive(1'b1, PN[6-j], PN[6-j], j == 0);
        rst = 1'b1;
        drive(1'b1, PN[1], PN[1], 1'b0);
        check_zero_outputs("midreset");
        rst = 1'b0;
        for (int k = 0; k < 8; k++) drive(1'b1, PN[6 - (k % 7)], PN[6 - (k % 7)], 1'b0);
        send_bit(7'b0000000, 1'b1, -1, 7, 1'b0, 1'b0);
        send_bit(7'b0000000, 1'b0, -1, 7, 1'b0, 1'b1);

        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b0;
        check("queue_drained", sb.size(), 0);
        check("strobe_count", int'(strobes), int'(pushes));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
